// File: rtl/jtframe_obj_pkg.sv
// Shared types for the object-ROM slot: FSM states and the tag-store entry layout.
package jtframe_obj_pkg;

  localparam int NENTRIES = 2;
  // Tags are stored zero-extended to the widest supported object address.
  localparam int TAG_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } obj_state_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [15:0]      data;
  } obj_entry_t;

endpackage

// File: rtl/jtframe_obj_tagstore.sv
// Two-entry tag store with LRU replacement, combinational hit lookup and a fill write port.
module jtframe_obj_tagstore
  import jtframe_obj_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill_we,
  input  logic [AW-1:0] fill_tag,
  input  logic [15:0]   fill_data,
  output logic          hit,
  output logic [15:0]   data
);

  obj_entry_t          ent [NENTRIES];
  logic                lru;
  logic                hit_idx;
  logic                fill_idx;
  logic [NENTRIES-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      match[i] = ent[i].valid && (ent[i].tag == TAG_W'(addr));
    end
    hit      = cs && (|match);
    hit_idx  = ~match[0];
    data     = hit ? ent[hit_idx].data : 16'h0000;
    // A hit in the fill cycle moves the pointer first, so the hit entry survives.
    fill_idx = hit ? ~hit_idx : lru;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lru <= 1'b0;
      for (int i = 0; i < NENTRIES; i++) begin
        ent[i] <= '0;
      end
    end else begin
      if (fill_we) begin
        ent[fill_idx] <= '{valid: 1'b1, tag: TAG_W'(fill_tag), data: fill_data};
        lru           <= ~fill_idx;
      end else if (hit) begin
        lru <= ~hit_idx;
      end
    end
  end

endmodule

// File: rtl/jtframe_obj_romslot.sv
// Object-ROM responder: tag-store lookup in front of an SDRAM req/ack/rdy fetch FSM.
// Define JTFRAME_OBJ_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module jtframe_obj_romslot
  import jtframe_obj_pkg::*;
#(
  parameter int AW = 13,
  parameter int SW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] offset,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic [15:0]   obj_data,
  output logic          obj_ok,
  output logic          sdram_req,
  output logic [SW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_din
`ifdef JTFRAME_OBJ_STATS_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
`endif
);

  obj_state_e    state, state_nx;
  logic [AW-1:0] ptag, ptag_nx;
  logic          req_nx;
  logic [SW-1:0] saddr_nx;
  logic          fill_we;

  jtframe_obj_tagstore #(.AW(AW)) u_tags (
    .clk       (clk),
    .rst       (rst),
    .cs        (obj_cs),
    .addr      (obj_addr),
    .fill_we   (fill_we),
    .fill_tag  (ptag),
    .fill_data (sdram_din),
    .hit       (obj_ok),
    .data      (obj_data)
  );

  always_comb begin
    state_nx = state;
    ptag_nx  = ptag;
    req_nx   = sdram_req;
    saddr_nx = sdram_addr;
    fill_we  = 1'b0;
    case (state)
      IDLE: begin
        if (obj_cs && !obj_ok) begin
          ptag_nx  = obj_addr;
          saddr_nx = offset + SW'(obj_addr);
          req_nx   = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_nx = 1'b0;
          if (sdram_rdy) begin
            fill_we  = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdram_rdy) begin
          fill_we  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptag       <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      state      <= state_nx;
      ptag       <= ptag_nx;
      sdram_req  <= req_nx;
      sdram_addr <= saddr_nx;
    end
  end

`ifdef JTFRAME_OBJ_STATS_EN
  logic miss;
  assign miss = (state == IDLE) && (state_nx == REQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else begin
      if (obj_ok && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtframe_obj_romslot.sv
// Self-checking bench: recency-ordered cache model plus transaction-level fetch model, randomized SDRAM timing.
module tb_jtframe_obj_romslot;

  localparam int AW = 13;
  localparam int SW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [SW-1:0] offset = '0;
  logic          obj_cs = 1'b0;
  logic [AW-1:0] obj_addr = '0;
  logic [15:0]   obj_data;
  logic          obj_ok;
  logic          sdram_req;
  logic [SW-1:0] sdram_addr;
  logic          sdram_ack = 1'b0;
  logic          sdram_rdy = 1'b0;
  logic [15:0]   sdram_din = '0;
`ifdef JTFRAME_OBJ_STATS_EN
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;
`endif

  jtframe_obj_romslot #(.AW(AW), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .offset     (offset),
    .obj_cs     (obj_cs),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_din  (sdram_din)
`ifdef JTFRAME_OBJ_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Cache contents ordered most-recently-used first.
  logic [AW-1:0] mq_addr[$];
  logic [15:0]   mq_data[$];
  // Fetch transaction: 0 none, 1 waiting for ack, 2 waiting for data.
  int            m_phase = 0;
  logic [AW-1:0] m_tag = '0;
  logic          m_req = 1'b0;
  logic [SW-1:0] m_saddr = '0;
  int            m_hits = 0;
  int            m_misses = 0;

  logic          auto_en = 1'b0;
  int            r_st = 0;
  int            r_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model at the falling edge, then advance the model.
  task automatic settle();
    int            idx;
    logic          e_ok;
    logic [15:0]   e_data;
    logic [AW-1:0] a;
    logic [15:0]   d;
    @(negedge clk);
    if (!rst) begin
      mq_addr.delete();
      mq_data.delete();
      m_phase  = 0;
      m_req    = 1'b0;
      m_saddr  = '0;
      m_hits   = 0;
      m_misses = 0;
    end
    idx = -1;
    if (rst && obj_cs) begin
      foreach (mq_addr[i]) if (mq_addr[i] == obj_addr) idx = i;
    end
    e_ok   = (idx >= 0);
    e_data = e_ok ? mq_data[idx] : 16'h0000;
    chk("obj_ok", {31'd0, obj_ok}, {31'd0, e_ok});
    chk("obj_data", {16'd0, obj_data}, {16'd0, e_data});
    chk("sdram_req", {31'd0, sdram_req}, {31'd0, m_req});
    chk("sdram_addr", {10'd0, sdram_addr}, {10'd0, m_saddr});
`ifdef JTFRAME_OBJ_STATS_EN
    chk("hit_cnt", {16'd0, hit_cnt}, (m_hits > 65535) ? 32'd65535 : m_hits);
    chk("miss_cnt", {16'd0, miss_cnt}, (m_misses > 65535) ? 32'd65535 : m_misses);
`endif
    if (rst) begin
      if (e_ok) begin
        m_hits++;
        a = mq_addr[idx];
        d = mq_data[idx];
        mq_addr.delete(idx);
        mq_data.delete(idx);
        mq_addr.push_front(a);
        mq_data.push_front(d);
      end
      if ((m_phase == 1 && sdram_ack && sdram_rdy) || (m_phase == 2 && sdram_rdy)) begin
        if (mq_addr.size() == 2) begin
          void'(mq_addr.pop_back());
          void'(mq_data.pop_back());
        end
        mq_addr.push_front(m_tag);
        mq_data.push_front(sdram_din);
      end
      if (m_phase == 0) begin
        if (obj_cs && !e_ok) begin
          m_tag   = obj_addr;
          m_saddr = SW'((int'(offset) + int'(obj_addr)) % (1 << SW));
          m_req   = 1'b1;
          m_phase = 1;
          m_misses++;
        end
      end else if (m_phase == 1) begin
        if (sdram_ack) begin
          m_req   = 1'b0;
          m_phase = sdram_rdy ? 0 : 2;
        end
      end else if (sdram_rdy) begin
        m_phase = 0;
      end
    end
  endtask

  // Step past the rising edge; ack/rdy default to idle and the optional responder reacts.
  task automatic advance();
    @(posedge clk);
    #1;
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    if (!rst) begin
      r_st = 0;
    end else if (auto_en) begin
      if (r_st == 0 && sdram_req) begin
        r_cnt = $urandom_range(0, 3);
        r_st  = 1;
      end
      if (r_st == 1) begin
        if (r_cnt == 0) begin
          sdram_ack = 1'b1;
          r_cnt     = $urandom_range(0, 3);
          r_st      = 2;
        end else begin
          r_cnt--;
        end
      end
      if (r_st == 2) begin
        if (r_cnt == 0) begin
          sdram_rdy = 1'b1;
          sdram_din = 16'($urandom);
          r_st      = 0;
        end else begin
          r_cnt--;
        end
      end
    end
  endtask

  // Called right after the settle of a miss cycle: ack at once, data one cycle later.
  task automatic serve(input logic [15:0] din);
    advance();
    sdram_ack = 1'b1;
    settle();
    advance();
    sdram_rdy = 1'b1;
    sdram_din = din;
    settle();
    advance();
  endtask

  task automatic fetch_manual(input logic [AW-1:0] a, input logic [15:0] din);
    obj_addr = a;
    obj_cs   = 1'b1;
    settle();
    chk("fetch_miss_ok", {31'd0, obj_ok}, 32'd0);
    serve(din);
  endtask

  logic [AW-1:0] pool [5];

  initial begin
    // 1: reset state, first miss, fill latency
    settle();
    chk("rst_req", {31'd0, sdram_req}, 32'd0);
    chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
    chk("rst_ok", {31'd0, obj_ok}, 32'd0);
    chk("rst_data", {16'd0, obj_data}, 32'd0);
    advance();
    rst      = 1'b1;
    offset   = 22'h100000;
    obj_cs   = 1'b1;
    obj_addr = 13'h0012;
    settle();
    chk("t1_req_not_yet", {31'd0, sdram_req}, 32'd0);
    advance();
    sdram_ack = 1'b1;
    settle();
    chk("t1_req", {31'd0, sdram_req}, 32'd1);
    chk("t1_addr", {10'd0, sdram_addr}, 32'h100012);
    advance();
    sdram_rdy = 1'b1;
    sdram_din = 16'hBEEF;
    settle();
    advance();
    settle();
    chk("t1_ok", {31'd0, obj_ok}, 32'd1);
    chk("t1_data", {16'd0, obj_data}, 32'h0000BEEF);
`ifdef JTFRAME_OBJ_STATS_EN
    for (int i = 0; i < 9; i++) begin
      advance();
      settle();
    end
    advance();
    settle();
    chk("t6_hit_cnt", {16'd0, hit_cnt}, 32'd10);
    chk("t6_miss_cnt", {16'd0, miss_cnt}, 32'd1);
`endif
    advance();

    // 2: two entries, alternating hits without SDRAM traffic
    fetch_manual(13'h0034, 16'h3434);
    for (int i = 0; i < 50; i++) begin
      obj_addr = (i % 2 == 1) ? 13'h0034 : 13'h0012;
      settle();
      chk("t2_ok", {31'd0, obj_ok}, 32'd1);
      chk("t2_req", {31'd0, sdram_req}, 32'd0);
      advance();
    end

    // 3: LRU eviction
    obj_addr = 13'h0034;
    settle();
    advance();
    fetch_manual(13'h0056, 16'h5656);
    obj_addr = 13'h0034;
    settle();
    chk("t3_keep_ok", {31'd0, obj_ok}, 32'd1);
    chk("t3_keep_data", {16'd0, obj_data}, 32'h3434);
    advance();
    fetch_manual(13'h0012, 16'h2222);

    // 4: address moves during WAIT; fill lands under the original tag
    rst = 1'b0;
    settle();
    advance();
    rst      = 1'b1;
    obj_addr = 13'h0012;
    settle();
    advance();
    sdram_ack = 1'b1;
    settle();
    advance();
    obj_addr  = 13'h0099;
    sdram_rdy = 1'b1;
    sdram_din = 16'h1111;
    settle();
    chk("t4_wait_ok", {31'd0, obj_ok}, 32'd0);
    advance();
    settle();
    chk("t4_new_miss", {31'd0, obj_ok}, 32'd0);
    advance();
    sdram_ack = 1'b1;
    settle();
    chk("t4_addr", {10'd0, sdram_addr}, 32'h100099);
    advance();
    sdram_rdy = 1'b1;
    sdram_din = 16'h3333;
    settle();
    advance();
    settle();
    chk("t4_99_data", {16'd0, obj_data}, 32'h3333);
    advance();
    obj_addr = 13'h0012;
    settle();
    chk("t4_12_ok", {31'd0, obj_ok}, 32'd1);
    chk("t4_12_data", {16'd0, obj_data}, 32'h1111);
    advance();

    // 5: reset mid-fetch, late rdy ignored
    rst = 1'b0;
    settle();
    advance();
    rst      = 1'b1;
    obj_addr = 13'h0040;
    settle();
    advance();
    rst = 1'b0;
    settle();
    chk("t5_req_drop", {31'd0, sdram_req}, 32'd0);
    chk("t5_ok_drop", {31'd0, obj_ok}, 32'd0);
    advance();
    rst    = 1'b1;
    obj_cs = 1'b0;
    settle();
    advance();
    sdram_rdy = 1'b1;
    sdram_din = 16'h5555;
    settle();
    advance();
    obj_cs = 1'b1;
    settle();
    chk("t5_no_fill", {31'd0, obj_ok}, 32'd0);
    serve(16'h4040);

    // Randomized traffic with random controller latencies
    auto_en = 1'b1;
    pool[0] = 13'h0000;
    pool[1] = 13'h1FFF;
    for (int i = 2; i < 5; i++) pool[i] = AW'($urandom_range(0, 8191));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) obj_addr = pool[$urandom_range(0, 4)];
      obj_cs = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) offset = ($urandom_range(0, 1) == 0) ? 22'h3FFFF0 : SW'($urandom);
      rst = ($urandom_range(0, 299) != 0);
      settle();
      advance();
    end
    rst = 1'b1;
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
